// File: rtl/bsg_fsb_htif_node_ctrl_pkg.sv
// Shared types for the FSB node front end: ring packet layout and switch opcodes.
// No logic, no latency.
// No flow control; types only.
package bsg_fsb_htif_node_ctrl_pkg;

  localparam int ring_width_lp = 80;

  // Ring packet, MSB first
  typedef struct packed {
    logic [3:0]  srcid;
    logic [3:0]  destid;
    logic        cmd;
    logic [6:0]  opcode;
    logic [63:0] data;
  } ring_packet_s;

  typedef enum logic [6:0] {
    OP_ENABLE  = 7'd1,
    OP_DISABLE = 7'd2,
    OP_RESET   = 7'd3
  } bsg_fsb_node_opcode_e;

  // Replace the source id of an outgoing packet with this node's id
  function automatic ring_packet_s stamp_src(input ring_packet_s pkt, input logic [3:0] id);
    ring_packet_s p;
    p       = pkt;
    p.srcid = id;
    return p;
  endfunction

endpackage

// File: rtl/bsg_fsb_htif_node_ctrl_if.sv
// Bundle of ring-side and connector-side handshakes plus node status for the node front end.
// No logic, no latency.
// Ring in: ready/valid; ring out: valid/yumi; connector out: ready/valid; connector in: valid/yumi.
interface bsg_fsb_htif_node_ctrl_if
  import bsg_fsb_htif_node_ctrl_pkg::*;
#(
  parameter int ring_width_p     = ring_width_lp,
  parameter int drop_cnt_width_p = 8
);
  logic                        v_i;
  logic [ring_width_p-1:0]     data_i;
  logic                        ready_o;
  logic                        v_o;
  logic [ring_width_p-1:0]     data_o;
  logic                        yumi_i;
  logic                        node_v_o;
  logic [ring_width_p-1:0]     node_data_o;
  logic                        node_ready_i;
  logic                        node_v_i;
  logic [ring_width_p-1:0]     node_data_i;
  logic                        node_yumi_o;
  logic                        node_en_r_o;
  logic                        node_reset_r_o;
  logic [drop_cnt_width_p-1:0] drop_cnt_r_o;

  // Node controller side
  modport slave (
    input  v_i, data_i, yumi_i, node_ready_i, node_v_i, node_data_i,
    output ready_o, v_o, data_o, node_v_o, node_data_o, node_yumi_o,
           node_en_r_o, node_reset_r_o, drop_cnt_r_o
  );

  // Ring / connector environment side
  modport master (
    output v_i, data_i, yumi_i, node_ready_i, node_v_i, node_data_i,
    input  ready_o, v_o, data_o, node_v_o, node_data_o, node_yumi_o,
           node_en_r_o, node_reset_r_o, drop_cnt_r_o
  );
endinterface

// File: rtl/bsg_fsb_htif_node_ctrl_cmd_fsm.sv
// Switch-command FSM: DIS/EN/RST state, node-reset pulse counter, en/reset status outputs.
// Command takes effect at the next clock edge; RST lasts exactly reset_cycles_p cycles.
// No handshake; the caller only presents cmd_v when not in RST.
module bsg_fsb_htif_node_ctrl_cmd_fsm
  import bsg_fsb_htif_node_ctrl_pkg::*;
#(
  parameter int reset_cycles_p = 8
)(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmd_v,
  input  logic [6:0] opcode,
  output logic       en_r,
  output logic       reset_r
);
  localparam int cnt_width_lp = (reset_cycles_p > 1) ? $clog2(reset_cycles_p) : 1;

  typedef enum logic [1:0] {DIS, EN, RST} state_e;

  state_e                  state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;

  // State and reset-counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= DIS;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next state: commands move between DIS/EN or into RST; RST counts down back to DIS
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      DIS: begin
        if (cmd_v && opcode == OP_ENABLE) state_n = EN;
        if (cmd_v && opcode == OP_RESET) begin
          state_n = RST;
          cnt_n   = cnt_width_lp'(reset_cycles_p - 1);
        end
      end
      EN: begin
        if (cmd_v && opcode == OP_DISABLE) state_n = DIS;
        if (cmd_v && opcode == OP_RESET) begin
          state_n = RST;
          cnt_n   = cnt_width_lp'(reset_cycles_p - 1);
        end
      end
      RST: begin
        if (cnt_r == '0) state_n = DIS;
        else             cnt_n   = cnt_r - 1'b1;
      end
      default: state_n = DIS;
    endcase
  end

  assign en_r    = (state_r == EN);
  assign reset_r = (state_r == RST);

endmodule

// File: rtl/bsg_fsb_htif_node_ctrl.sv
// FSB node front end: filters ring packets by destid, decodes switch commands, forwards data, stamps srcid.
// Ring->connector 1 cycle (one-entry input reg, full throughput); connector->ring 1 cycle (one-entry output reg).
// ready_o = buffer empty or draining this cycle; commands stall while in node reset; connector input taken only when enabled.
module bsg_fsb_htif_node_ctrl
  import bsg_fsb_htif_node_ctrl_pkg::*;
#(
  parameter int         ring_width_p     = ring_width_lp,
  parameter logic [3:0] id_p             = 4'h0,
  parameter int         reset_cycles_p   = 8,
  parameter int         drop_cnt_width_p = 8
)(
  input logic                   clk_i,
  input logic                   reset_i,
  bsg_fsb_htif_node_ctrl_if.slave bus
);
  ring_packet_s                in_r, out_r;
  logic                        in_v_r, out_v_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;
  logic                        in_deq, drop, cmd_take, node_v;
  logic                        node_en, node_rst, node_yumi;

  bsg_fsb_htif_node_ctrl_cmd_fsm #(.reset_cycles_p(reset_cycles_p)) fsm (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .cmd_v   (cmd_take),
    .opcode  (in_r.opcode),
    .en_r    (node_en),
    .reset_r (node_rst)
  );

  // Classify the held packet: drop, command, or forward to the connector
  always_comb begin
    in_deq   = 1'b0;
    drop     = 1'b0;
    cmd_take = 1'b0;
    node_v   = 1'b0;
    if (in_v_r) begin
      if (in_r.destid != id_p) begin
        in_deq = 1'b1;
        drop   = 1'b1;
      end else if (in_r.cmd) begin
        // commands wait out the node reset so they are never lost
        in_deq   = ~node_rst;
        cmd_take = ~node_rst;
      end else if (node_en) begin
        node_v = 1'b1;
        in_deq = bus.node_ready_i;
      end else begin
        in_deq = 1'b1;
        drop   = 1'b1;
      end
    end
  end

  assign node_yumi = bus.node_v_i & node_en & (~out_v_r | bus.yumi_i);

  // Ring input register; enqueue and dequeue may coincide
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_v_r <= 1'b0;
      in_r   <= '0;
    end else if (bus.v_i && bus.ready_o) begin
      in_v_r <= 1'b1;
      in_r   <= bus.data_i;
    end else if (in_deq) begin
      in_v_r <= 1'b0;
    end
  end

  // Ring output register, loaded with the connector packet restamped with our id
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_v_r <= 1'b0;
      out_r   <= '0;
    end else if (node_yumi) begin
      out_v_r <= 1'b1;
      out_r   <= stamp_src(bus.node_data_i, id_p);
    end else if (bus.yumi_i) begin
      out_v_r <= 1'b0;
    end
  end

  // Saturating dropped-packet counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                    drop_cnt_r <= '0;
    else if (drop && ~&drop_cnt_r)  drop_cnt_r <= drop_cnt_r + 1'b1;
  end

  assign bus.ready_o        = ~in_v_r | in_deq;
  assign bus.v_o            = out_v_r;
  assign bus.data_o         = ring_width_p'(out_r);
  assign bus.node_v_o       = node_v;
  assign bus.node_data_o    = ring_width_p'(in_r);
  assign bus.node_yumi_o    = node_yumi;
  assign bus.node_en_r_o    = node_en;
  assign bus.node_reset_r_o = node_rst;
  assign bus.drop_cnt_r_o   = drop_cnt_r;

endmodule
